corr_stream_core: RTL and testbench
===================================

Name: corr_stream_core

Overview:
Parametrised memory-to-correlator-to-memory streaming engine; successor to the single-width correlator core.
- Reads LEN signed samples from on-chip memory starting at src_base and passes each one to the correlator datapath.
- Takes the correlator result, converts it by the latched mode (magnitude or signed), scales and saturates it, then writes it to dst_base.
- Sits between the Avalon-side register slave (start, lengths, bases) and the shared internal memory bus.

Parameters:
DW, 8, sample and output data width
AW, 16, address/length width
ACC_W, 25, correlator result width
SHIFT, 12, output = result bits [SHIFT+DW-1:SHIFT] before saturation
PRIME, 1, number of leading outputs forced to zero (correlator fill latency)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle start request, honoured only in IDLE
abort  in  1  cancel request
mode  in  1  0 = magnitude, 1 = signed; latched at start
len  in  AW  samples to process
src_base  in  AW  first read address
dst_base  in  AW  first write address
busy  out  1  high whenever not IDLE
done  out  1  one-cycle pulse on return to IDLE (normal or abort)
mem_addr  out  AW  memory address
mem_read  out  1  read strobe, one cycle
mem_write  out  1  write strobe, one cycle
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid with mem_rdy
mem_rdy  in  1  transaction complete
corr_in  out  DW  signed sample to correlator
corr_start  out  1  one-cycle sample strobe
corr_out  in  ACC_W  signed correlator result
corr_valid  in  1  corr_out valid

Behaviour:
- Reset: state IDLE; all outputs 0; index, latched mode and internal registers 0.
- Datapath outputs and strobes are driven combinationally from state and are 0 outside their own state.
- State machine:
  - IDLE: on start, latch mode/len/src/dst and clear index i. If len==0, go to IDLE with done=1 and no bus traffic; else go to RD.
  - RD: mem_addr=src_base+i, mem_read=1 -> WAIT_RD.
  - WAIT_RD: stay until mem_rdy; capture mem_rdata -> SEND.
  - SEND: corr_in=captured sample, corr_start=1 -> WAIT_CORR.
  - WAIT_CORR: stay until corr_valid; capture the converted result -> WR.
  - WR: mem_addr=dst_base+i, mem_write=1, mem_wdata=result -> WAIT_WR.
  - WAIT_WR: stay until mem_rdy -> NEXT.
  - NEXT: if i==len-1, go to IDLE with done=1; else i=i+1 -> RD.
- Address arithmetic is modulo 2^AW; wrap past 0xFFFF is legal and continues at 0.
- Magnitude mode:
  - m = |corr_out|, computed ACC_W+1 wide so the most negative value is exact.
  - If any bit of m above SHIFT+DW-1 is set, result = all ones; else result = m[SHIFT+DW-1:SHIFT].
- Signed mode:
  - s = corr_out >>> SHIFT.
  - Clamp s to [-2^(DW-1), 2^(DW-1)-1]; result = low DW bits.
- Priming: if i < PRIME, the write still occurs but mem_wdata = 0. The correlator is still fed that sample.
- Abort:
  - In RD, SEND, WR or NEXT: go to IDLE next cycle with done=1.
  - In WAIT_RD or WAIT_WR: finish the bus transaction (wait for mem_rdy), then go to IDLE with done=1. No half-finished bus cycles.
  - In WAIT_CORR: drop the pending result and go to IDLE.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: start wins.
- Asynchronous reset mid-operation: immediate return to IDLE, no done pulse.
- Throughput: 7 cycles per sample plus the wait states.

Optional Feature:
PEAK_TRACK_EN
- Compiled in:
  - Adds outputs peak_val [DW] and peak_idx [AW], both cleared at start.
  - On each WR with i >= PRIME, if result > peak_val (unsigned in magnitude mode, signed in signed mode), update peak_val=result and peak_idx=i. Ties keep the earlier index.
  - Both values hold after done until the next start.
- Compiled out: the ports do not exist and no peak logic is present.

Test Plan:
1. Magnitude mode, len=3, PRIME=1, memory {0x05,0x06,0x07}, corr_out replies {0x0001000, 0x0012345, 0x1FEDCBB (=-0x12345)} -> writes {0x00, 0x12, 0x12} at dst_base..+2, then a single done pulse.
2. Saturation, PRIME=0: magnitude mode with corr_out=0x0100000 -> 0xFF. Signed mode with corr_out=-0x100000 -> 0x80, and with 0x0070000 -> 0x70.
3. len=0 start -> done the cycle after, busy never asserted, no mem_read/mem_write.
4. src_base=0xFFFF, len=2 -> reads at 0xFFFF then 0x0000; writes follow the same wrap.
5. Abort asserted during WAIT_WR with mem_rdy delayed 3 cycles -> mem_write seen once, IDLE reached only after mem_rdy, done=1, no further reads.
6. PEAK_TRACK_EN, magnitude mode, results {0x10, 0x40, 0x40, 0x20} -> peak_val=0x40, peak_idx=1.

Source files
------------

// File: rtl/corr_stream_core.sv
// Memory -> correlator -> memory streaming engine: fetches LEN samples, feeds the correlator,
// converts/scales/saturates each result and writes it back. Define PEAK_TRACK_EN for peak tracking.
module corr_stream_core #(
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int ACC_W = 25,
    parameter int SHIFT = 12,
    parameter int PRIME = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [AW-1:0]    len,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_rdy,
    output logic [DW-1:0]    corr_in,
    output logic             corr_start,
    input  logic [ACC_W-1:0] corr_out,
    input  logic             corr_valid,
    output logic [2:0]       state_dbg
`ifdef PEAK_TRACK_EN
    ,
    output logic [DW-1:0]    peak_val,
    output logic [AW-1:0]    peak_idx
`endif
);

    // Memory bus handshake: mem_read/mem_write are one-cycle strobes with mem_addr (and
    // mem_wdata) valid in that cycle; the transaction ends in the first cycle mem_rdy is high,
    // which is also when mem_rdata is valid. The correlator side mirrors this with
    // corr_start (one cycle, corr_in valid) and corr_valid (corr_out valid).

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD        = 3'd1,
        S_WAIT_RD   = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_CORR = 3'd4,
        S_WR        = 3'd5,
        S_WAIT_WR   = 3'd6,
        S_NEXT      = 3'd7
    } state_t;

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    state_t        state, state_n;
    logic          mode_q;
    logic [AW-1:0] len_q, src_q, dst_q, idx;
    logic [DW-1:0] sample_q, result_q;
    logic          abort_pend;

    logic done_n, load, cap_sample, cap_result, inc_idx, pend_set;

    logic [ACC_W:0]           corr_ext, mag;
    logic signed [ACC_W-1:0]  s_shift;
    logic [DW-1:0]            mag_res, sgn_res, conv_res;

    assign state_dbg = state;

    // Next-state and control decode
    always_comb begin
        state_n    = state;
        done_n     = 1'b0;
        load       = 1'b0;
        cap_sample = 1'b0;
        cap_result = 1'b0;
        inc_idx    = 1'b0;
        pend_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) done_n = 1'b1;
                    else           state_n = S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (mem_rdy) begin
                    if (abort || abort_pend) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        cap_sample = 1'b1;
                        state_n    = S_SEND;
                    end
                end else if (abort) begin
                    pend_set = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_WAIT_CORR;
                end
            end
            S_WAIT_CORR: begin
                if (abort) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else if (corr_valid) begin
                    cap_result = 1'b1;
                    state_n    = S_WR;
                end
            end
            S_WR: begin
                if (abort) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_WAIT_WR;
                end
            end
            S_WAIT_WR: begin
                if (mem_rdy) begin
                    if (abort || abort_pend) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_NEXT;
                    end
                end else if (abort) begin
                    pend_set = 1'b1;
                end
            end
            S_NEXT: begin
                if (abort || idx == len_q - AW'(1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    inc_idx = 1'b1;
                    state_n = S_RD;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= done_n;
        end
    end

    // Result conversion: magnitude is formed one bit wider so the most negative input is exact
    always_comb begin
        corr_ext = {corr_out[ACC_W-1], corr_out};
        mag      = corr_out[ACC_W-1] ? (~corr_ext + (ACC_W+1)'(1)) : corr_ext;
        if ((mag >> (SHIFT + DW)) != '0) mag_res = '1;
        else                             mag_res = mag[SHIFT+DW-1:SHIFT];

        s_shift = $signed(corr_out) >>> SHIFT;
        if (s_shift > S_MAX)      sgn_res = S_MAX[DW-1:0];
        else if (s_shift < S_MIN) sgn_res = S_MIN[DW-1:0];
        else                      sgn_res = s_shift[DW-1:0];

        conv_res = mode_q ? sgn_res : mag_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 1'b0;
            len_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            idx        <= '0;
            sample_q   <= '0;
            result_q   <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (load) begin
                mode_q <= mode;
                len_q  <= len;
                src_q  <= src_base;
                dst_q  <= dst_base;
                idx    <= '0;
            end else if (inc_idx) begin
                idx <= idx + AW'(1);
            end
            if (cap_sample) sample_q <= mem_rdata;
            // Leading outputs cover the correlator fill latency and are written as zero
            if (cap_result) result_q <= (idx < AW'(PRIME)) ? '0 : conv_res;
            if (load)                abort_pend <= 1'b0;
            else if (pend_set)       abort_pend <= 1'b1;
            else if (state_n == S_IDLE) abort_pend <= 1'b0;
        end
    end

    // Bus and correlator outputs are pure decodes of the current state
    always_comb begin
        busy       = (state != S_IDLE);
        mem_addr   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        corr_in    = '0;
        corr_start = 1'b0;
        case (state)
            S_RD: begin
                mem_addr = src_q + idx;
                mem_read = 1'b1;
            end
            S_SEND: begin
                corr_in    = sample_q;
                corr_start = 1'b1;
            end
            S_WR: begin
                mem_addr  = dst_q + idx;
                mem_write = 1'b1;
                mem_wdata = result_q;
            end
            default: ;
        endcase
    end

`ifdef PEAK_TRACK_EN
    logic peak_gt;

    always_comb begin
        if (mode_q) peak_gt = ($signed(result_q) > $signed(peak_val));
        else        peak_gt = (result_q > peak_val);
    end

    // Strict greater-than keeps the earliest index on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_val <= '0;
            peak_idx <= '0;
        end else if (load) begin
            peak_val <= '0;
            peak_idx <= '0;
        end else if (state == S_WR && idx >= AW'(PRIME) && peak_gt) begin
            peak_val <= result_q;
            peak_idx <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_corr_stream_core.sv
// Directed bench for corr_stream_core: memory and correlator responders log traffic,
// the main sequence pushes expected reads/samples/writes and compares after each job.
module tb_corr_stream_core;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int ACC_W = 25;
    localparam int SHIFT = 12;
    localparam int PRIME = 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             mode;
    logic [AW-1:0]    len;
    logic [AW-1:0]    src_base;
    logic [AW-1:0]    dst_base;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_addr;
    logic             mem_read;
    logic             mem_write;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             mem_rdy = 1'b0;
    logic [DW-1:0]    corr_in;
    logic             corr_start;
    logic [ACC_W-1:0] corr_out = '0;
    logic             corr_valid = 1'b0;
    logic [2:0]       state_dbg;
`ifdef PEAK_TRACK_EN
    logic [DW-1:0]    peak_val;
    logic [AW-1:0]    peak_idx;
`endif

    corr_stream_core #(
        .DW(DW), .AW(AW), .ACC_W(ACC_W), .SHIFT(SHIFT), .PRIME(PRIME)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .len(len), .src_base(src_base), .dst_base(dst_base),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .corr_in(corr_in), .corr_start(corr_start),
        .corr_out(corr_out), .corr_valid(corr_valid),
        .state_dbg(state_dbg)
`ifdef PEAK_TRACK_EN
        , .peak_val(peak_val), .peak_idx(peak_idx)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    logic [DW-1:0]    exp_samp_q[$];
    logic [AW+DW-1:0] obs_wr_q[$];
    logic [AW-1:0]    obs_rd_q[$];
    logic [DW-1:0]    obs_samp_q[$];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int samp_ptr = 0;

    logic [DW-1:0]    mem [0:65535];
    logic [ACC_W-1:0] corr_tab [0:63];
    int corr_fill = 0;
    int corr_ptr  = 0;
    int rdy_delay = 1;

    int done_cnt = 0;
    int busy_cnt = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    logic [AW-1:0]    resp_addr;
    logic             resp_wr;
    logic [ACC_W-1:0] corr_val;

    always @(negedge clk) begin
        if (done)      done_cnt++;
        if (busy)      busy_cnt++;
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
    end

    // Memory responder
    always begin
        @(negedge clk);
        if (mem_read || mem_write) begin
            resp_addr = mem_addr;
            resp_wr   = mem_write;
            if (resp_wr) obs_wr_q.push_back({mem_addr, mem_wdata});
            else         obs_rd_q.push_back(mem_addr);
            repeat (rdy_delay) @(negedge clk);
            mem_rdata = resp_wr ? '0 : mem[resp_addr];
            mem_rdy   = 1'b1;
            @(negedge clk);
            mem_rdy   = 1'b0;
            mem_rdata = '0;
        end
    end

    // Correlator responder
    always begin
        @(negedge clk);
        if (corr_start) begin
            obs_samp_q.push_back(corr_in);
            corr_val = corr_tab[corr_ptr % 64];
            corr_ptr++;
            @(negedge clk);
            corr_out   = corr_val;
            corr_valid = 1'b1;
            @(negedge clk);
            corr_valid = 1'b0;
            corr_out   = '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_step(input logic [AW-1:0] ra, input logic [DW-1:0] smp,
                             input logic [ACC_W-1:0] cv, input logic [AW-1:0] wa,
                             input logic [DW-1:0] res);
        mem[ra] = smp;
        exp_rd_q.push_back(ra);
        exp_samp_q.push_back(smp);
        corr_tab[corr_fill % 64] = cv;
        corr_fill++;
        exp_q.push_back({wa, res});
    endtask

    task automatic drain(input string tag);
        check({tag, "_nrd"}, obs_rd_q.size() - rd_ptr, exp_rd_q.size());
        while (exp_rd_q.size() != 0) begin
            if (rd_ptr < obs_rd_q.size()) begin
                check({tag, "_rd_addr"}, obs_rd_q[rd_ptr], exp_rd_q[0]);
                rd_ptr++;
            end
            void'(exp_rd_q.pop_front());
        end
        rd_ptr = obs_rd_q.size();
        check({tag, "_nsamp"}, obs_samp_q.size() - samp_ptr, exp_samp_q.size());
        while (exp_samp_q.size() != 0) begin
            if (samp_ptr < obs_samp_q.size()) begin
                check({tag, "_sample"}, obs_samp_q[samp_ptr], exp_samp_q[0]);
                samp_ptr++;
            end
            void'(exp_samp_q.pop_front());
        end
        samp_ptr = obs_samp_q.size();
        check({tag, "_nwr"}, obs_wr_q.size() - wr_ptr, exp_q.size());
        while (exp_q.size() != 0) begin
            if (wr_ptr < obs_wr_q.size()) begin
                check({tag, "_wr"}, obs_wr_q[wr_ptr], exp_q[0]);
                wr_ptr++;
            end
            void'(exp_q.pop_front());
        end
        wr_ptr = obs_wr_q.size();
    endtask

    task automatic start_job(input logic m, input logic [AW-1:0] l, input logic [AW-1:0] s,
                             input logic [AW-1:0] d, input logic ab);
        mode     = m;
        len      = l;
        src_base = s;
        dst_base = d;
        abort    = ab;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 400 && !done; k++) @(negedge clk);
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_done_1cyc"}, done, 0);
    endtask

    int d0, r0, w0, b0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode = 1'b0;
        len = '0;
        src_base = '0;
        dst_base = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", mem_read, 0);
        check("rst_write", mem_write, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_corr_start", corr_start, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        // Magnitude mode with priming and a negative result
        push_step(16'h0100, 8'h05, 25'h0001000, 16'h0200, 8'h00);
        push_step(16'h0101, 8'h06, 25'h0012345, 16'h0201, 8'h12);
        push_step(16'h0102, 8'h07, 25'h1FEDCBB, 16'h0202, 8'h12);
        d0 = done_cnt;
        start_job(1'b0, 16'd3, 16'h0100, 16'h0200, 1'b0);
        wait_done("t1");
        repeat (3) @(negedge clk);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_idle", busy, 0);
        drain("t1");

        // Magnitude saturation and the most negative input
        push_step(16'h0700, 8'h01, 25'h0000000, 16'h0710, 8'h00);
        push_step(16'h0701, 8'h02, 25'h0100000, 16'h0711, 8'hFF);
        push_step(16'h0702, 8'h03, 25'h1000000, 16'h0712, 8'hFF);
        push_step(16'h0703, 8'h04, 25'h00AB000, 16'h0713, 8'hAB);
        start_job(1'b0, 16'd4, 16'h0700, 16'h0710, 1'b0);
        wait_done("t2m");
        drain("t2m");

        // Signed mode clamps and a small negative value
        push_step(16'h0720, 8'h11, 25'h0000000, 16'h0730, 8'h00);
        push_step(16'h0721, 8'h12, 25'h1F00000, 16'h0731, 8'h80);
        push_step(16'h0722, 8'h13, 25'h0070000, 16'h0732, 8'h70);
        push_step(16'h0723, 8'h14, 25'h1FFB000, 16'h0733, 8'hFB);
        push_step(16'h0724, 8'h15, 25'h0080000, 16'h0734, 8'h7F);
        start_job(1'b1, 16'd5, 16'h0720, 16'h0730, 1'b0);
        wait_done("t2s");
        drain("t2s");

        // Zero length: done next cycle with no bus traffic
        d0 = done_cnt;
        r0 = rd_cnt;
        w0 = wr_cnt;
        b0 = busy_cnt;
        start_job(1'b0, 16'd0, 16'h0010, 16'h0020, 1'b0);
        check("t3_done_next", done, 1);
        check("t3_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("t3_done_count", done_cnt - d0, 1);
        check("t3_reads", rd_cnt - r0, 0);
        check("t3_writes", wr_cnt - w0, 0);
        check("t3_busy_count", busy_cnt - b0, 0);

        // Address wrap, with abort alongside start (start wins)
        push_step(16'hFFFF, 8'h21, 25'h0003000, 16'hFFFF, 8'h00);
        push_step(16'h0000, 8'h22, 25'h0005000, 16'h0000, 8'h05);
        start_job(1'b0, 16'd2, 16'hFFFF, 16'hFFFF, 1'b1);
        check("t4_busy_after_start_abort", busy, 1);
        wait_done("t4");
        drain("t4");

        // Abort in WAIT_WR with a slow memory
        rdy_delay = 3;
        push_step(16'h0300, 8'h09, 25'h0020000, 16'h0400, 8'h00);
        d0 = done_cnt;
        r0 = rd_cnt;
        w0 = wr_cnt;
        start_job(1'b0, 16'd3, 16'h0300, 16'h0400, 1'b0);
        for (int k = 0; k < 200 && !mem_write; k++) @(negedge clk);
        check("t5_write_seen", mem_write, 1);
        @(negedge clk);
        abort = 1'b1;
        check("t5_in_wait_wr", state_dbg, 6);
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy_pending", busy, 1);
        @(negedge clk);
        check("t5_busy_until_rdy", busy, 1);
        wait_done("t5");
        repeat (10) @(negedge clk);
        check("t5_reads", rd_cnt - r0, 1);
        check("t5_writes", wr_cnt - w0, 1);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_idle", busy, 0);
        drain("t5");
        rdy_delay = 1;

`ifdef PEAK_TRACK_EN
        // Peak tracking skips primed outputs; ties keep the earlier index
        push_step(16'h0500, 8'h31, 25'h007F000, 16'h0600, 8'h00);
        push_step(16'h0501, 8'h32, 25'h0010000, 16'h0601, 8'h10);
        push_step(16'h0502, 8'h33, 25'h0040000, 16'h0602, 8'h40);
        push_step(16'h0503, 8'h34, 25'h0040000, 16'h0603, 8'h40);
        push_step(16'h0504, 8'h35, 25'h0020000, 16'h0604, 8'h20);
        start_job(1'b0, 16'd5, 16'h0500, 16'h0600, 1'b0);
        wait_done("t6");
        repeat (3) @(negedge clk);
        check("t6_peak_val", peak_val, 8'h40);
        check("t6_peak_idx", peak_idx, 16'd2);
        drain("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
